// File: rtl/operand_fetch_ctrl_if.sv
// operand_fetch_ctrl_if: command, operand-memory, ALU and result buses of the operand fetch controller
interface operand_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W = 3
);
  logic cmd_valid;
  logic cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [ADDR_W-1:0] cmd_addr1;
  logic [ADDR_W-1:0] cmd_addr2;
  logic [ADDR_W-1:0] operand1_addr;
  logic [DATA_W-1:0] operand1_value;
  logic [ADDR_W-1:0] operand2_addr;
  logic [DATA_W-1:0] operand2_value;
  logic alu_start;
  logic [OP_W-1:0] alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic alu_done;
  logic [DATA_W-1:0] alu_result;
  logic res_valid;
  logic res_ready;
  logic [DATA_W-1:0] res_data;
  logic err;
  logic busy;
  logic [15:0] ops_done;
  modport master (
    input cmd_valid, cmd_op, cmd_addr1, cmd_addr2, operand1_value, operand2_value,
          alu_done, alu_result, res_ready,
    output cmd_ready, operand1_addr, operand2_addr, alu_start, alu_op, alu_a, alu_b,
           res_valid, res_data, err, busy, ops_done
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr1, cmd_addr2, operand1_value, operand2_value,
           alu_done, alu_result, res_ready,
    input cmd_ready, operand1_addr, operand2_addr, alu_start, alu_op, alu_a, alu_b,
          res_valid, res_data, err, busy, ops_done
  );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: fetches two operands, launches the ALU and returns its result; OPCTRL_TIMEOUT_EN adds an ALU watchdog
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  operand_fetch_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [OP_W-1:0] op_r;
  logic [ADDR_W-1:0] addr1_r, addr2_r;
  logic [DATA_W-1:0] a_r, b_r, res_r;
  logic err_r;
  logic [15:0] ops_done_r;
  logic tmo;
`ifdef OPCTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // watchdog counts WAIT cycles; held at zero elsewhere so it starts clean on every WAIT entry
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 1'b1 : '0;
  assign tmo = state == WAIT && !bus.alu_done && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: single command in flight, no bypass from RESP to a new command
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = FETCH;
      FETCH: state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: if (bus.alu_done || tmo) state_nxt = RESP;
      RESP: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath registers: command capture, operand latch, result capture, handshake counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= '0;
      addr1_r <= '0;
      addr2_r <= '0;
      a_r <= '0;
      b_r <= '0;
      res_r <= '0;
      err_r <= 1'b0;
      ops_done_r <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        op_r <= bus.cmd_op;
        addr1_r <= bus.cmd_addr1;
        addr2_r <= bus.cmd_addr2;
      end
      if (state == FETCH) begin
        a_r <= bus.operand1_value;
        b_r <= bus.operand2_value;
      end
      if (state == WAIT && (bus.alu_done || tmo)) begin
        res_r <= bus.alu_done ? bus.alu_result : '0;
        err_r <= !bus.alu_done;
      end
      if (state == RESP && bus.res_ready) ops_done_r <= ops_done_r + 16'd1;
    end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.alu_start = state == ISSUE;
  assign bus.res_valid = state == RESP;
  assign bus.operand1_addr = addr1_r;
  assign bus.operand2_addr = addr2_r;
  assign bus.alu_op = op_r;
  assign bus.alu_a = a_r;
  assign bus.alu_b = b_r;
  assign bus.res_data = res_r;
  assign bus.err = err_r;
  assign bus.ops_done = ops_done_r;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: directed and randomized checks of operand_fetch_ctrl against a transaction-level model
module tb_operand_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] m1 [16];
  logic [15:0] m2 [16];
  logic [15:0] exp_ops = '0;
  operand_fetch_ctrl_if bus ();
  operand_fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.operand1_value = m1[bus.operand1_addr];
  assign bus.operand2_value = m2[bus.operand2_addr];
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return a;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // IDLE -> FETCH -> ISSUE -> first WAIT cycle, checking each stage; returns at the WAIT negedge
  task automatic launch(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr1 = a1;
    bus.cmd_addr2 = a2;
    chk("idle_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'($urandom);
    bus.cmd_addr1 = 4'($urandom);
    bus.cmd_addr2 = 4'($urandom);
    bus.alu_done = 1'($urandom);
    bus.alu_result = 16'($urandom);
    chk("fetch_busy", {15'd0, bus.busy}, 16'd1);
    chk("fetch_start", {15'd0, bus.alu_start}, 16'd0);
    chk("fetch_addr1", {12'd0, bus.operand1_addr}, {12'd0, a1});
    chk("fetch_addr2", {12'd0, bus.operand2_addr}, {12'd0, a2});
    @(negedge clk);
    bus.alu_done = 1'($urandom);
    chk("issue_start", {15'd0, bus.alu_start}, 16'd1);
    chk("issue_alu_a", bus.alu_a, m1[a1]);
    chk("issue_alu_b", bus.alu_b, m2[a2]);
    chk("issue_alu_op", {13'd0, bus.alu_op}, {13'd0, op});
    @(negedge clk);
    bus.alu_done = 1'b0;
  endtask
  // completes a command: ALU answers after dly extra WAIT cycles, consumer stalls for hold cycles
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2, input int dly, input int hold);
    logic [15:0] exp;
    exp = alu_fn(op, m1[a1], m2[a2]);
    launch(op, a1, a2);
    repeat (dly) begin
      chk("wait_res_valid", {15'd0, bus.res_valid}, 16'd0);
      chk("wait_start", {15'd0, bus.alu_start}, 16'd0);
      @(negedge clk);
    end
    bus.alu_done = 1'b1;
    bus.alu_result = exp;
    @(negedge clk);
    bus.alu_done = 1'b0;
    bus.alu_result = 16'($urandom);
    chk("resp_valid", {15'd0, bus.res_valid}, 16'd1);
    chk("resp_data", bus.res_data, exp);
    chk("resp_err", {15'd0, bus.err}, 16'd0);
    chk("resp_cmd_ready", {15'd0, bus.cmd_ready}, 16'd0);
    bus.cmd_valid = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {15'd0, bus.res_valid}, 16'd1);
      chk("hold_data", bus.res_data, exp);
      chk("hold_err", {15'd0, bus.err}, 16'd0);
      chk("hold_cmd_ready", {15'd0, bus.cmd_ready}, 16'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_ops++;
    chk("done_ops", bus.ops_done, exp_ops);
    chk("done_busy", {15'd0, bus.busy}, 16'd0);
    chk("done_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    chk("done_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("done_res_hold", bus.res_data, exp);
    chk("done_addr1_hold", {12'd0, bus.operand1_addr}, {12'd0, a1});
    chk("done_op_hold", {13'd0, bus.alu_op}, {13'd0, op});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr1 = '0;
    bus.cmd_addr2 = '0;
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m1[i] = 16'($urandom);
      m2[i] = 16'($urandom);
    end
    m1[0] = 16'hA935;
    m2[3] = 16'h1234;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("rst_start", {15'd0, bus.alu_start}, 16'd0);
    chk("rst_err", {15'd0, bus.err}, 16'd0);
    chk("rst_ops", bus.ops_done, 16'h0000);
    chk("rst_res_data", bus.res_data, 16'h0000);
    chk("rst_alu_a", bus.alu_a, 16'h0000);
    run_cmd(3'd0, 4'd0, 4'd3, 0, 0);
    chk("basic_sum", bus.res_data, 16'hBB69);
    chk("basic_ops", bus.ops_done, 16'h0001);
    run_cmd(3'd1, 4'd5, 4'd7, 2, 5);
    launch(3'd2, 4'd9, 4'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_start", {15'd0, bus.alu_start}, 16'd0);
    chk("arst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("arst_busy", {15'd0, bus.busy}, 16'd0);
    chk("arst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = '0;
    bus.alu_done = 1'b1;
    bus.alu_result = 16'hBEEF;
    @(negedge clk);
    bus.alu_done = 1'b0;
    chk("late_done_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("late_done_busy", {15'd0, bus.busy}, 16'd0);
    chk("late_done_data", bus.res_data, 16'h0000);
    chk("late_done_ops", bus.ops_done, exp_ops);
`ifdef OPCTRL_TIMEOUT_EN
    launch(3'd4, 4'd1, 4'd2);
    repeat (8) begin
      chk("tmo_wait_valid", {15'd0, bus.res_valid}, 16'd0);
      @(negedge clk);
    end
    chk("tmo_valid", {15'd0, bus.res_valid}, 16'd1);
    chk("tmo_err", {15'd0, bus.err}, 16'd1);
    chk("tmo_data", bus.res_data, 16'h0000);
    bus.alu_done = 1'b1;
    bus.alu_result = 16'h5A5A;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    bus.res_ready = 1'b0;
    exp_ops++;
    chk("tmo_ops", bus.ops_done, exp_ops);
    chk("tmo_back_idle", {15'd0, bus.busy}, 16'd0);
    chk("tmo_late_ignored", bus.res_data, 16'h0000);
    run_cmd(3'd3, 4'd6, 4'd8, 7, 1);
`else
    run_cmd(3'd4, 4'd1, 4'd2, 20, 1);
`endif
    for (int n = 0; n < 40; n++)
      run_cmd(3'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
    force dut.ops_done_r = 16'hFFFF;
    #1 release dut.ops_done_r;
    exp_ops = 16'hFFFF;
    chk("wrap_preload", bus.ops_done, exp_ops);
    run_cmd(3'($urandom), 4'($urandom), 4'($urandom), 0, 0);
    chk("wrap_zero", bus.ops_done, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
